// File: rtl/apb_fifo_arbiter_if.sv
// APB link between the arbiter (master) and the FIFO slave.
// PADDR selects the queue: 0 = write queue, 1 = read queue.
interface apb_fifo_arbiter_if #(
  parameter int unsigned DW = 8
);
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic          PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_arbiter.sv
// Two-requester round-robin arbiter issuing single APB push/pop transfers to a FIFO slave,
// with a per-transfer wait timeout. Every output comes straight from a register.
module apb_fifo_arbiter #(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                req0,
  input  logic                req1,
  input  logic                wr0,
  input  logic                wr1,
  input  logic [DW-1:0]       wdata0,
  input  logic [DW-1:0]       wdata1,
  output logic                done0,
  output logic                done1,
  output logic                err,
  output logic                tout,
  output logic [DW-1:0]       rdata,
  output logic                busy,
  apb_fifo_arbiter_if.master  apb
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e        state_q, state_d;
  logic          last_q, last_d;  // requester granted most recently
  logic          gnt_q, gnt_d;    // requester owning the current transfer
  logic [7:0]    cnt_q, cnt_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic          paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err_q, err_d;
  logic          tout_q, tout_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;

  logic          gnt_sel;
  logic          wr_sel;

  always_comb begin
    gnt_sel   = (req0 && req1) ? ~last_q : req1;
    wr_sel    = gnt_sel ? wr1 : wr0;

    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = err_q;
    tout_d    = tout_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d   = StSetup;
          gnt_d     = gnt_sel;
          last_d    = gnt_sel;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = wr_sel;
          paddr_d   = ~wr_sel;
          pwdata_d  = wr_sel ? (gnt_sel ? wdata1 : wdata0) : '0;
          busy_d    = 1'b1;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        cnt_d     = 8'd0;
      end
      StAccess: begin
        if (apb.PSLVERR || apb.PREADY || (cnt_q + 8'd1 == TimeoutCnt)) begin
          state_d   = StDone;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done0_d   = ~gnt_q;
          done1_d   = gnt_q;
          if (apb.PSLVERR || apb.PREADY) begin
            // PSLVERR wins over PREADY; read data is only taken on a clean pop.
            err_d  = apb.PSLVERR;
            tout_d = 1'b0;
            if (!pwrite_q && !apb.PSLVERR) begin
              rdata_d = apb.PRDATA;
            end
          end else begin
            err_d  = 1'b1;
            tout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;  // requester 0 wins the first contention
      gnt_q     <= 1'b0;
      cnt_q     <= 8'd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 1'b0;
      pwdata_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      tout_q    <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign apb.PSELx   = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err         = err_q;
  assign tout        = tout_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;

endmodule

// File: doc/apb_fifo_arbiter.md
APB_FIFO_ARBITER -- requirements
Module: apb_fifo_arbiter

Interface
REQ-001 Parameter DW, 8, data width of the write and read data paths.
REQ-002 Parameter TIMEOUT, 15, maximum ACCESS cycles without PREADY/PSLVERR before forced completion (range 1..255).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; ports: PCLK (in, 1, rising-edge clock), PRESETn (in, 1, async active-low reset).
REQ-004 req0, req1  in  1  requester transfer request; held high until the matching done.
REQ-005 wr0, wr1  in  1  requester op: 1 = push (FIFO write), 0 = pop (FIFO read).
REQ-006 wdata0, wdata1  in  DW  requester push data.
REQ-007 done0, done1  out  1  one-cycle completion pulse to the granted requester.
REQ-008 err  out  1  completion status, valid with done: 1 = slave error or timeout.
REQ-009 tout  out  1  valid with done: 1 = completion caused by timeout.
REQ-010 rdata  out  DW  pop data, valid with done when the op was a pop and err=0.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 PSELx, PENABLE, PWRITE, PADDR  out  1  APB master controls to the FIFO slave; PADDR 0 = write queue, 1 = read queue.
REQ-013 PWDATA  out  DW  APB write data.
REQ-014 PRDATA  in  DW; PREADY, PSLVERR  in  1  APB slave response.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, ACCESS and DONE; all outputs SHALL be driven from registers.
REQ-016 IDLE: if req0 or req1 is high at a PCLK edge, the block SHALL grant one requester, latch its wr/wdata, and enter SETUP; otherwise it remains in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; a single request is granted directly; the pointer updates only on grant.
REQ-018 SETUP (one cycle): PSELx=1, PENABLE=0, PWRITE=wr, PADDR=~wr, PWDATA=latched wdata (0 for pops).
REQ-019 ACCESS: PSELx=1, PENABLE=1, with PWRITE/PADDR/PWDATA held stable from SETUP.
REQ-020 ACCESS SHALL complete at the first edge where PREADY=1 or PSLVERR=1: capture err=PSLVERR and tout=0, capture rdata=PRDATA if pop and PSLVERR=0, then enter DONE.
REQ-021 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; at TIMEOUT cycles without a response, complete with err=1, tout=1, rdata unchanged, and enter DONE.
REQ-022 If PSLVERR and PREADY are both high, PSLVERR SHALL take precedence (err=1).
REQ-023 DONE (one cycle): PSELx=0, PENABLE=0, the granted done pulses high for exactly this cycle, and requests are ignored; the next state is IDLE.
REQ-024 Minimum request-to-done latency SHALL be 3 cycles (IDLE sample -> SETUP -> ACCESS -> DONE); back-to-back transfers SHALL take 4 cycles each.
REQ-025 err, tout and rdata SHALL hold their values until the next DONE.
REQ-026 Deasserting a request after grant SHALL NOT abort the transfer, and done SHALL still pulse.

Reset
REQ-027 On PRESETn=0, asynchronously: state=IDLE, all outputs 0, counter 0, round-robin pointer set so requester 0 wins the first contention.
REQ-028 Reset mid-transfer SHALL drop PSELx and PENABLE immediately and discard the transfer with no done pulse.

Verification
REQ-029 req0=1, wr0=1, wdata0=8'hA5, slave PREADY in the first ACCESS cycle -> SETUP with PWRITE=1, PADDR=0, PWDATA=A5, then ACCESS; done0 pulses 3 cycles after the sample with err=0.
REQ-030 Pop on a non-empty FIFO holding 8'h3C (req1=1, wr1=0) -> PADDR=1, PWRITE=0; done1 pulses with rdata=3C and err=0.
REQ-031 req0 and req1 both held high for 4 transfers from reset -> grant order 0,1,0,1 and each done spaced 4 cycles.
REQ-032 Pop on an empty FIFO (PSLVERR=1) -> done with err=1, tout=0, and rdata unchanged.
REQ-033 PREADY and PSLVERR held 0 with TIMEOUT=15 -> 15 ACCESS cycles, then done with err=1 and tout=1.
REQ-034 PRESETn pulsed low during ACCESS -> PSELx=0 and PENABLE=0 at once, no done, busy=0; the next request after release is granted to requester 0 under contention.
